testeio_serial_mem_loader: RTL and testbench
============================================

# testeio_serial_mem_loader

Serial packet loader that sits directly upstream of the 32K×32 two-port on-chip memory and drives its second port (s2). It takes a byte stream from the UART receiver, parses framed load packets, packs payload bytes into 32-bit words and writes them to consecutive memory word addresses. It reports completion, checksum and timeout errors to the control logic.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles allowed between bytes inside a packet before abort.
- `HEADER_BYTE`, default 8'hA5: start-of-packet marker.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  received byte.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid & in_ready`.
- `address2`  out  15  memory word address.
- `writedata2`  out  32  memory write data.
- `byteenable2`  out  4  always 4'hF.
- `chipselect2`  out  1  asserted only together with `write2`.
- `write2`  out  1  single-cycle write strobe. The memory has no waitrequest.
- `busy`  out  1  high from header acceptance until packet end.
- `done`  out  1  one-cycle pulse on good packet end.
- `error`  out  1  one-cycle pulse on bad packet end.
- `err_code`  out  2  0 none, 1 checksum, 2 timeout; held until the next header is accepted.
- `words_written`  out  16  words written in the current or last packet.

## Operation
- Packet format: HEADER, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, 4×N data bytes, CHK.
  - The start address is the low 15 bits of {ADDR_HI, ADDR_LO}; bit 15 is ignored.
  - N = {CNT_HI, CNT_LO}, range 0..65535.
  - Each word is little-endian: the first byte goes to writedata2[7:0].
  - CHK is the XOR of all bytes from ADDR_HI through the last data byte.
- State machine states: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHK, END.
  - IDLE: a byte equal to HEADER_BYTE moves to ADDR_HI, clears `err_code` and `words_written`, and sets `busy`. Any other byte is dropped with no error.
  - ADDR_HI → ADDR_LO → CNT_HI → CNT_LO: one accepted byte each.
  - CNT_LO: go to DATA if N ≠ 0, otherwise to CHK.
  - DATA: byte lane counter 0..3. On the 4th byte of a word, register the write for the next cycle, then increment the address and `words_written`. Move to CHK after word N is packed.
  - CHK: compare the accepted byte with the running XOR. Match → `done`; mismatch → `error` with `err_code`=1. Then go to END.
  - END: one cycle with `in_ready`=0 and `busy` dropping. Then return to IDLE.
- Address wraps from 32767 to 0. This is not an error.
- Words written before a checksum or timeout failure stay in memory; there is no rollback.
- Timeout:
  - A counter runs in every state except IDLE and END, and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: pulse `error` with `err_code`=2, drop `busy`, and go to IDLE.
  - A pending word write registered in the same cycle still completes.
- Reset values: all outputs 0 except `byteenable2`=4'hF. State is IDLE and the address, counters and XOR are cleared.
- Asserting `reset_n` mid-packet abandons the packet immediately. No pulse is issued, and a write not yet driven is lost.

## Timing
- `in_ready` is 1 in every state except END and reset.
  - Back-to-back bytes (valid every cycle) must be sustained.
  - The write for word k is issued one cycle after its 4th byte. It never collides with word k+1, which needs at least 3 more cycles.
- `write2`/`chipselect2` are high for exactly one cycle per word. `address2` and `writedata2` are stable during that cycle.
- `done`/`error` are asserted the cycle after the CHK byte is accepted. `busy` falls in the same cycle.
- Latency from the last data byte to its memory write is 1 cycle. From the CHK byte to `done` it is 1 cycle.
- Registered outputs only; there are no combinational paths from inputs to outputs except `in_ready`, which is decoded from state.

## Structure
- Package `testeio_loader_pkg` holds:
  - the state enum;
  - the `ERR_NONE`, `ERR_CHECKSUM` and `ERR_TIMEOUT` constants;
  - the default HEADER_BYTE.
- One sub-module, `testeio_loader_timeout`: a loadable down-counter with `clear`, `enable` and an `expired` output, parameterised by TIMEOUT_CYCLES.

## Test plan
- Packet addr 0x0010, N=2, bytes 11 22 33 44 55 66 77 88, correct CHK → writes 0x44332211 at 0x0010 and 0x88776655 at 0x0011; `done` pulses once; `words_written`=2.
- Same packet with CHK XOR 0x01 → both words written; `error` pulses; `err_code`=1.
- Packet addr 0x7FFF, N=2 → writes at 0x7FFF then 0x0000.
- N=0 with correct CHK (ADDR_HI^ADDR_LO^0^0) → no `write2`; `done` pulses.
- Stall 3 bytes into DATA for TIMEOUT_CYCLES (set to 16 in the bench) → `error` and `err_code`=2 at cycle 16; no write; the next header is accepted normally.
- Garbage bytes 0x00 and 0xFF before the header, and `reset_n` pulsed mid-DATA → garbage ignored; after reset, outputs are at reset values and no `done`/`error` is issued.

Source files
------------

// File: rtl/testeio_loader_pkg.sv
// Shared types and constants for the serial memory loader.
//   state_e             : packet parser states
//   ERR_*               : err_code encodings reported to control logic
//   DEFAULT_HEADER_BYTE : default start-of-packet marker
package testeio_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CHK,
    ST_END
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

endpackage

// File: rtl/testeio_loader_timeout.sv
// Inter-byte timeout down-counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : reload the counter (byte accepted or timer idle)
//   enable       : count this cycle
//   expired      : TIMEOUT_CYCLES enabled cycles have elapsed since the last clear
module testeio_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= LOAD;
    end else if (clear) begin
      r_count <= LOAD;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Loaded with N-1, so the N-th idle cycle sees zero and fires.
  assign expired = enable && (r_count == '0);

endmodule

// File: rtl/testeio_serial_mem_loader.sv
// Serial packet loader driving port 2 of the 32Kx32 on-chip memory.
// Packet: HEADER, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, 4*N data bytes, CHK.
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_data/valid/ready  : byte stream from UART receiver
//   address2, writedata2, byteenable2, chipselect2, write2 : memory port 2
//   busy, done, error, err_code, words_written : status to control logic
module testeio_serial_mem_loader
  import testeio_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  HEADER_BYTE    = DEFAULT_HEADER_BYTE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [14:0] address2,
  output logic [31:0] writedata2,
  output logic [3:0]  byteenable2,
  output logic        chipselect2,
  output logic        write2,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_written
);

  state_e r_state, w_next;

  logic        r_rdy;
  logic [6:0]  r_addr_hi;
  logic [7:0]  r_cnt_hi;
  logic [7:0]  r_xor;
  logic [14:0] r_addr;
  logic [15:0] r_n;
  logic [15:0] r_words;
  logic [1:0]  r_lane;
  logic [23:0] r_buf;
  logic        r_write;
  logic [14:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [1:0]  r_err_code;

  logic w_accept;
  logic w_last_word;
  logic w_timer_en;
  logic w_timer_clr;
  logic w_expired;

  // r_rdy keeps in_ready low while in reset without a combinational reset path.
  assign in_ready    = r_rdy && (r_state != ST_END);
  assign w_accept    = in_valid && in_ready;
  assign w_last_word = (r_lane == 2'd3) && ((r_words + 16'd1) == r_n);
  assign w_timer_en  = (r_state != ST_IDLE) && (r_state != ST_END);
  assign w_timer_clr = w_accept || !w_timer_en;

  testeio_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (w_timer_clr),
    .enable (w_timer_en && !w_accept),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept && (in_data == HEADER_BYTE)) w_next = ST_ADDR_HI;
      ST_ADDR_HI: if (w_accept) w_next = ST_ADDR_LO;
      ST_ADDR_LO: if (w_accept) w_next = ST_CNT_HI;
      ST_CNT_HI:  if (w_accept) w_next = ST_CNT_LO;
      ST_CNT_LO:  if (w_accept) w_next = ({r_cnt_hi, in_data} != 16'd0) ? ST_DATA : ST_CHK;
      ST_DATA:    if (w_accept && w_last_word) w_next = ST_CHK;
      ST_CHK:     if (w_accept) w_next = ST_END;
      ST_END:     w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    // Expiry only happens on cycles without an accepted byte.
    if (w_expired) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy      <= 1'b0;
      r_addr_hi  <= '0;
      r_cnt_hi   <= '0;
      r_xor      <= '0;
      r_addr     <= '0;
      r_n        <= '0;
      r_words    <= '0;
      r_lane     <= '0;
      r_buf      <= '0;
      r_write    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_rdy   <= 1'b1;
      r_write <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;

      if (w_expired) begin
        r_error    <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
        r_busy     <= 1'b0;
      end

      if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (in_data == HEADER_BYTE) begin
              r_err_code <= ERR_NONE;
              r_words    <= '0;
              r_busy     <= 1'b1;
              r_xor      <= '0;
              r_lane     <= '0;
            end
          end
          ST_ADDR_HI: begin
            r_addr_hi <= in_data[6:0];
            r_xor     <= r_xor ^ in_data;
          end
          ST_ADDR_LO: begin
            r_addr <= {r_addr_hi, in_data};
            r_xor  <= r_xor ^ in_data;
          end
          ST_CNT_HI: begin
            r_cnt_hi <= in_data;
            r_xor    <= r_xor ^ in_data;
          end
          ST_CNT_LO: begin
            r_n   <= {r_cnt_hi, in_data};
            r_xor <= r_xor ^ in_data;
          end
          ST_DATA: begin
            r_xor <= r_xor ^ in_data;
            if (r_lane == 2'd3) begin
              r_write   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= {in_data, r_buf};
              r_addr    <= r_addr + 15'd1;
              r_words   <= r_words + 16'd1;
              r_lane    <= '0;
            end else begin
              // Shift in from the top so lane 0 ends up in the low byte.
              r_buf  <= {in_data, r_buf[23:8]};
              r_lane <= r_lane + 2'd1;
            end
          end
          ST_CHK: begin
            r_busy <= 1'b0;
            if (in_data == r_xor) begin
              r_done <= 1'b1;
            end else begin
              r_error    <= 1'b1;
              r_err_code <= ERR_CHECKSUM;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign address2      = r_wr_addr;
  assign writedata2    = r_wr_data;
  assign byteenable2   = 4'hF;
  assign chipselect2   = r_write;
  assign write2        = r_write;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign err_code      = r_err_code;
  assign words_written = r_words;

endmodule

// File: tb/tb_testeio_serial_mem_loader.sv
// Scoreboard bench for testeio_serial_mem_loader: packet tasks push expected
// memory writes and end-of-packet events; a negedge monitor pops and compares.
module tb_testeio_serial_mem_loader;
  import testeio_loader_pkg::*;

  localparam int unsigned TO  = 16;
  localparam logic [7:0]  HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] address2;
  logic [31:0] writedata2;
  logic [3:0]  byteenable2;
  logic        chipselect2;
  logic        write2;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_written;

  testeio_serial_mem_loader #(
    .TIMEOUT_CYCLES(TO),
    .HEADER_BYTE(HDR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .address2(address2), .writedata2(writedata2),
    .byteenable2(byteenable2), .chipselect2(chipselect2), .write2(write2),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [14:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic is_err; logic [1:0] code; logic [15:0] words; int cyc; } ev_t;
  wr_t wr_q[$];
  ev_t ev_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor
  wr_t mw;
  ev_t me;
  always @(negedge clk) begin
    if (write2 === 1'b1 || chipselect2 === 1'b1) begin
      check("wr_strobe", {chipselect2, write2}, 2'b11);
      check("wr_byteen", byteenable2, 4'hF);
      if (wr_q.size() == 0) begin
        check("unexpected_write", address2, 64'hFFFF_FFFF);
      end else begin
        mw = wr_q.pop_front();
        check("wr_addr", address2, mw.addr);
        check("wr_data", writedata2, mw.data);
        check("wr_cycle", cyc, mw.cyc);
      end
    end
    if (done === 1'b1 || error === 1'b1) begin
      if (ev_q.size() == 0) begin
        check("unexpected_event", {done, error}, 2'b00);
      end else begin
        me = ev_q.pop_front();
        check("ev_kind", {done, error}, me.is_err ? 2'b01 : 2'b10);
        check("ev_code", err_code, me.code);
        check("ev_words", words_written, me.words);
        check("ev_busy", busy, 1'b0);
        check("ev_cycle", cyc, me.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Returns the index of the posedge at which the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_c);
    int tries;
    idle(gap);
    tries = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      tries++;
    end while (in_ready !== 1'b1 && tries < 8);
    check("accept", in_ready, 1'b1);
    acc_c = cyc + 1;
  endtask

  task automatic send_packet(input logic [15:0] a, input logic [15:0] n,
                             input logic [7:0] d[$], input logic [7:0] flip, input int maxgap);
    logic [7:0] x;
    int c;
    wr_t w;
    ev_t e;
    send_byte(HDR, $urandom_range(0, maxgap), c);
    send_byte(a[15:8], $urandom_range(0, maxgap), c);
    send_byte(a[7:0],  $urandom_range(0, maxgap), c);
    send_byte(n[15:8], $urandom_range(0, maxgap), c);
    send_byte(n[7:0],  $urandom_range(0, maxgap), c);
    x = a[15:8] ^ a[7:0] ^ n[15:8] ^ n[7:0];
    for (int k = 0; k < int'(n) * 4; k++) begin
      x = x ^ d[k];
      send_byte(d[k], $urandom_range(0, maxgap), c);
      if (k % 4 == 3) begin
        w.addr = 15'((int'(a) % 32768 + k / 4) % 32768);
        w.data = {d[k], d[k-1], d[k-2], d[k-3]};
        w.cyc  = c;
        wr_q.push_back(w);
      end
    end
    send_byte(x ^ flip, $urandom_range(0, maxgap), c);
    e.is_err = (flip != 8'h00);
    e.code   = (flip != 8'h00) ? ERR_CHECKSUM : ERR_NONE;
    e.words  = n;
    e.cyc    = c;
    ev_q.push_back(e);
  endtask

  task automatic drain;
    int t;
    idle(2);
    t = 0;
    while ((wr_q.size() != 0 || ev_q.size() != 0) && t < 200) begin
      idle(1);
      t++;
    end
    check("queues_empty", wr_q.size() + ev_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_outs"}, {address2, writedata2, chipselect2, write2, busy, done, error, err_code}, '0);
    check({tag, "_words"}, words_written, 16'd0);
    check({tag, "_byteen"}, byteenable2, 4'hF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d[$];
    int c;
    ev_t e;
    logic [15:0] n;
    logic [7:0] flip;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle(2);

    // Garbage before header, then the reference packet back to back.
    send_byte(8'h00, 0, c);
    send_byte(8'hFF, 0, c);
    idle(2);
    check("garbage_busy", busy, 1'b0);
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_packet(16'h0010, 16'd2, d, 8'h00, 0);
    drain();
    check("t1_words", words_written, 16'd2);
    check("t1_code", err_code, ERR_NONE);

    // Corrupted checksum: words still land; err_code held afterwards.
    send_packet(16'h0010, 16'd2, d, 8'h01, 2);
    drain();
    idle(3);
    check("t2_code_held", err_code, ERR_CHECKSUM);
    check("t2_words_held", words_written, 16'd2);

    // Address wrap.
    d = {};
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    send_packet(16'h7FFF, 16'd2, d, 8'h00, 1);
    drain();

    // Empty packet.
    d = {};
    send_packet(16'h1234, 16'd0, d, 8'h00, 1);
    drain();

    // Timeout three bytes into DATA.
    send_byte(HDR, 0, c);
    send_byte(8'h00, 0, c);
    send_byte(8'h40, 0, c);
    send_byte(8'h00, 0, c);
    send_byte(8'h02, 0, c);
    send_byte(8'hAA, 0, c);
    send_byte(8'hBB, 0, c);
    send_byte(8'hCC, 0, c);
    e.is_err = 1'b1; e.code = ERR_TIMEOUT; e.words = 16'd0; e.cyc = c + int'(TO);
    ev_q.push_back(e);
    idle(TO + 6);
    drain();
    check("to_busy", busy, 1'b0);
    check("to_code", err_code, ERR_TIMEOUT);
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_packet(16'h8005, 16'd1, d, 8'h00, 0);
    drain();

    // Reset mid-DATA abandons the packet silently.
    send_byte(8'h00, 0, c);
    send_byte(8'hFF, 1, c);
    send_byte(HDR, 0, c);
    send_byte(8'h01, 0, c);
    send_byte(8'h00, 0, c);
    send_byte(8'h00, 0, c);
    send_byte(8'h03, 0, c);
    send_byte(8'hDE, 0, c);
    send_byte(8'hAD, 0, c);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    idle(20);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_ready", in_ready, 1'b1);

    // Randomized packets.
    for (int p = 0; p < 12; p++) begin
      n = 16'($urandom_range(0, 4));
      d = {};
      for (int i = 0; i < int'(n) * 4; i++) d.push_back(8'($urandom));
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_packet(16'($urandom), n, d, flip, 3);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 4));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
